// File: rtl/vga_rx_monitor_if.sv
// vga_rx_monitor_if: TinyVGA byte in, decoded pixel stream, lock status and frame signature out
interface vga_rx_monitor_if;
  logic [7:0] vga_in;
  logic pix_valid;
  logic [5:0] rrggbb;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic locked;
  logic frame_done;
  logic [15:0] frame_sig;
  logic [7:0] err_count;
  modport master (
    output vga_in,
    input pix_valid, rrggbb, pix_x, pix_y, locked, frame_done, frame_sig, err_count
  );
  modport slave (
    input vga_in,
    output pix_valid, rrggbb, pix_x, pix_y, locked, frame_done, frame_sig, err_count
  );
endinterface

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: locks onto a TinyVGA timing stream, extracts active pixels and signs each locked frame
module vga_rx_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL = 800,
  parameter int H_START = 144,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL = 525,
  parameter int V_START = 35,
  parameter int SYNC_NEG = 1
) (
  input logic clk,
  input logic rst_n,
  vga_rx_monitor_if.slave bus
);
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
  localparam logic POL = (SYNC_NEG != 0);
  localparam logic [7:0] IDLE = POL ? 8'h88 : 8'h00;
  state_t state_q;
  logic [7:0] s1_q;
  logic hs2_q, vs2_q, chk_q, err_seen_q;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [15:0] sig_q, sig_d, sig_upd, frame_sig_q;
  logic pix_valid_q, frame_done_q;
  logic [5:0] rgb_q, rgb;
  logic [9:0] pix_x_q, pix_y_q;
  logic [7:0] err_count_q;
  logic hs1, vs1, h_edge, v_edge, line_err, frame_ok, h_sat, active, show;
  logic [10:0] lines;
  assign hs1 = s1_q[7] ^ POL;
  assign vs1 = s1_q[3] ^ POL;
  assign h_edge = hs1 & ~hs2_q;
  assign v_edge = vs1 & ~vs2_q;
  assign rgb = {s1_q[0], s1_q[4], s1_q[1], s1_q[5], s1_q[2], s1_q[6]};
  // counts describe the sample currently in S1, so hpos 0 is the hsync assert sample
  assign hcnt_d = h_edge ? '0 : (&hcnt_q ? hcnt_q : hcnt_q + 10'd1);
  assign vcnt_d = v_edge ? '0 : ((h_edge && !(&vcnt_q)) ? vcnt_q + 10'd1 : vcnt_q);
  assign h_sat = &hcnt_d;
  assign line_err = h_edge & chk_q & (({1'b0, hcnt_q} + 11'd1) != 11'(H_TOTAL));
  // an hsync edge coincident with vsync closes the last line of the frame
  assign lines = {1'b0, vcnt_q} + {10'd0, h_edge};
  assign frame_ok = lines == 11'(V_TOTAL);
  assign active = hcnt_d >= 10'(H_START) && hcnt_d < 10'(H_START + H_ACTIVE) &&
                  vcnt_d >= 10'(V_START) && vcnt_d < 10'(V_START + V_ACTIVE);
  assign show = active && state_q != SEARCH;
  assign sig_upd = active ? ({sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {10'd0, rgb}) : sig_q;
  assign sig_d = v_edge ? '0 : sig_upd;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      s1_q <= IDLE;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      chk_q <= 1'b0;
      err_seen_q <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      sig_q <= '0;
      frame_sig_q <= '0;
      pix_valid_q <= 1'b0;
      rgb_q <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      frame_done_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_q <= bus.vga_in;
      hs2_q <= hs1;
      vs2_q <= vs1;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      sig_q <= sig_d;
      pix_valid_q <= show;
      rgb_q <= show ? rgb : '0;
      pix_x_q <= show ? hcnt_d - 10'(H_START) : '0;
      pix_y_q <= show ? vcnt_d - 10'(V_START) : '0;
      frame_done_q <= 1'b0;
      // the first line after leaving SEARCH may be partial, so its length is not judged
      chk_q <= state_q != SEARCH && (chk_q || h_edge);
      case (state_q)
        SEARCH: if (v_edge) begin
          state_q <= ALIGN;
          err_seen_q <= 1'b0;
        end
        ALIGN: if (v_edge) begin
          state_q <= (!err_seen_q && !line_err && frame_ok) ? LOCKED : ALIGN;
          err_seen_q <= 1'b0;
        end else if (line_err) err_seen_q <= 1'b1;
        LOCKED: if (line_err || h_sat || (v_edge && !frame_ok)) begin
          state_q <= SEARCH;
          err_count_q <= err_count_q + {7'd0, ~&err_count_q};
        end else if (v_edge) begin
          frame_done_q <= 1'b1;
          frame_sig_q <= sig_upd;
        end
        default: state_q <= SEARCH;
      endcase
    end
  end
  assign bus.pix_valid = pix_valid_q;
  assign bus.rrggbb = rgb_q;
  assign bus.pix_x = pix_x_q;
  assign bus.pix_y = pix_y_q;
  assign bus.locked = state_q == LOCKED;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_sig = frame_sig_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed scenarios on a reduced 16x8 raster (8x4 active) with hand-computed expectations
module tb_vga_rx_monitor;
  localparam int HA = 8, HT = 16, HST = 4, VA = 4, VT = 8, VST = 2, HSW = 2, VSW = 1;
  localparam int BIG = 1 << 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vga_rx_monitor_if bus();
  vga_rx_monitor #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_START(HST),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_START(VST), .SYNC_NEG(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0, tk = 0, mode_cur = 0;
  int nval, nfd, nbad, maxx, maxy, sumx, sumy, first_k, drop_k, first_x, first_y;
  int fd_last = 0, fd_prev = 0;
  logic [5:0] first_rgb;
  function automatic logic [5:0] col(input int mode, input int x, input int y);
    return mode == 0 ? 6'b110000 : (((x + y) % 2) != 0 ? 6'b111100 : 6'b000011);
  endfunction
  function automatic logic [7:0] enc(input logic hs, input logic vs, input logic [5:0] c);
    return {~hs, c[0], c[2], c[4], ~vs, c[1], c[3], c[5]};
  endfunction
  function automatic logic [7:0] pix(input int mode, input int l, input int h);
    logic act = h >= HST && h < HST + HA && l >= VST && l < VST + VA;
    return enc(h < HSW, l < VSW, act ? col(mode, h - HST, l - VST) : 6'd0);
  endfunction
  function automatic logic [15:0] sig_model(input int mode);
    logic [15:0] s = '0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'd0, col(mode, x, y)};
    return s;
  endfunction
  task automatic clr();
    nval = 0; nfd = 0; nbad = 0; maxx = 0; maxy = 0; sumx = 0; sumy = 0;
    first_k = -1; drop_k = -1; first_x = -1; first_y = -1; first_rgb = '0; tk = 0;
  endtask
  // one clock: sample outputs at the falling edge, then drive the next input byte
  task automatic tick(input logic [7:0] v);
    @(negedge clk);
    if (bus.pix_valid) begin
      nval++;
      if (first_k < 0) begin
        first_k = tk; first_x = int'(bus.pix_x); first_y = int'(bus.pix_y); first_rgb = bus.rrggbb;
      end
      if (int'(bus.pix_x) > maxx) maxx = int'(bus.pix_x);
      if (int'(bus.pix_y) > maxy) maxy = int'(bus.pix_y);
      sumx += int'(bus.pix_x);
      sumy += int'(bus.pix_y);
      if (bus.rrggbb !== col(mode_cur, int'(bus.pix_x), int'(bus.pix_y))) nbad++;
    end else if (bus.rrggbb !== 6'd0) nbad++;
    if (bus.frame_done) begin nfd++; fd_prev = fd_last; fd_last = cyc; end
    if (!bus.locked && drop_k < 0) drop_k = tk;
    cyc++; tk++;
    bus.vga_in = v;
  endtask
  task automatic drive_frame(input int mode, input int short_l, input int nl, input int lim);
    int n = 0;
    mode_cur = mode;
    for (int l = 0; l < nl; l++)
      for (int h = 0; h < ((l == short_l) ? HT - 1 : HT); h++)
        if (n < lim) begin tick(pix(mode, l, h)); n++; end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick(enc(1'b0, 1'b0, 6'd0));
    checks++; if ({bus.pix_valid, bus.rrggbb, bus.pix_x, bus.pix_y} !== 27'd0) begin failures++; $display("FAIL reset_pix got=%h exp=0", {bus.pix_valid, bus.rrggbb, bus.pix_x, bus.pix_y}); end
    checks++; if ({bus.locked, bus.frame_done} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {bus.locked, bus.frame_done}); end
    checks++; if (bus.frame_sig !== 16'd0) begin failures++; $display("FAIL reset_sig got=%h exp=0", bus.frame_sig); end
    checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", bus.err_count); end
    rst_n = 1'b1;
  endtask
  task automatic test_lock();
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL lock_align got=%b exp=0", bus.locked); end
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL lock_second_edge got=%b exp=1", bus.locked); end
    checks++; if (nfd != 0) begin failures++; $display("FAIL lock_no_done_on_lock got=%0d exp=0", nfd); end
    checks++; if (nval != HA * VA) begin failures++; $display("FAIL lock_valid_count1 got=%0d exp=%0d", nval, HA * VA); end
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (nfd != 1) begin failures++; $display("FAIL lock_done got=%0d exp=1", nfd); end
    checks++; if (nval != HA * VA) begin failures++; $display("FAIL lock_valid_count2 got=%0d exp=%0d", nval, HA * VA); end
    checks++; if (maxx != HA - 1 || maxy != VA - 1) begin failures++; $display("FAIL lock_max_xy got=%0d,%0d exp=%0d,%0d", maxx, maxy, HA - 1, VA - 1); end
    checks++; if (sumx != 112 || sumy != 48) begin failures++; $display("FAIL lock_sum_xy got=%0d,%0d exp=112,48", sumx, sumy); end
    checks++; if (nbad != 0) begin failures++; $display("FAIL lock_colour got=%0d bad exp=0", nbad); end
    checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL lock_err got=%0d exp=0", bus.err_count); end
  endtask
  task automatic test_checker();
    clr(); drive_frame(1, -1, VT, BIG);
    checks++; if (first_k != VST * HT + HST + 2) begin failures++; $display("FAIL px00_latency got=%0d exp=%0d", first_k, VST * HT + HST + 2); end
    checks++; if (first_x != 0 || first_y != 0 || first_rgb !== 6'b000011) begin failures++; $display("FAIL px00_value got=%0d,%0d,%b exp=0,0,000011", first_x, first_y, first_rgb); end
    checks++; if (nbad != 0) begin failures++; $display("FAIL checker_colour got=%0d bad exp=0", nbad); end
    for (int f = 0; f < 2; f++) begin
      clr(); drive_frame(1, -1, VT, BIG);
      checks++; if (bus.frame_sig !== sig_model(1)) begin failures++; $display("FAIL checker_sig%0d got=%h exp=%h", f, bus.frame_sig, sig_model(1)); end
      checks++; if (nfd != 1 || fd_last - fd_prev != HT * VT) begin failures++; $display("FAIL checker_period%0d got=%0d/%0d exp=1/%0d", f, nfd, fd_last - fd_prev, HT * VT); end
    end
  endtask
  task automatic test_short_line();
    clr(); drive_frame(0, 5, VT, BIG);
    checks++; if (drop_k != 6 * HT - 1 + 2) begin failures++; $display("FAIL short_drop_time got=%0d exp=%0d", drop_k, 6 * HT + 1); end
    checks++; if (bus.err_count !== 8'd1) begin failures++; $display("FAIL short_err got=%0d exp=1", bus.err_count); end
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (bus.locked !== 1'b0 || nfd != 0) begin failures++; $display("FAIL short_still_align got=%b/%0d exp=0/0", bus.locked, nfd); end
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (bus.locked !== 1'b1 || nfd != 0) begin failures++; $display("FAIL short_relock got=%b/%0d exp=1/0", bus.locked, nfd); end
  endtask
  task automatic test_short_frame();
    clr(); drive_frame(0, -1, VT - 1, BIG);
    checks++; if (nfd != 1) begin failures++; $display("FAIL vloss_prev_done got=%0d exp=1", nfd); end
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (nfd != 0 || drop_k != 2) begin failures++; $display("FAIL vloss_edge got=%0d/%0d exp=0/2", nfd, drop_k); end
    checks++; if (bus.err_count !== 8'd2) begin failures++; $display("FAIL vloss_err got=%0d exp=2", bus.err_count); end
    clr(); drive_frame(0, -1, VT, BIG);
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL vloss_relock got=%b exp=1", bus.locked); end
  endtask
  task automatic test_hsync_stuck();
    clr();
    repeat (1100) tick(enc(1'b0, 1'b0, 6'd0));
    checks++; if (drop_k != 1009) begin failures++; $display("FAIL stuck_drop_time got=%0d exp=1009", drop_k); end
    checks++; if (bus.err_count !== 8'd3) begin failures++; $display("FAIL stuck_err got=%0d exp=3", bus.err_count); end
    checks++; if (nval != 0 || nfd != 0) begin failures++; $display("FAIL stuck_quiet got=%0d/%0d exp=0/0", nval, nfd); end
    clr(); drive_frame(0, -1, VT, BIG);
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL stuck_relock got=%b exp=1", bus.locked); end
  endtask
  task automatic test_reset_mid();
    clr(); drive_frame(0, -1, VT, 40);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({bus.pix_valid, bus.rrggbb, bus.pix_x, bus.pix_y} !== 27'd0) begin failures++; $display("FAIL rmid_pix got=%h exp=0", {bus.pix_valid, bus.rrggbb, bus.pix_x, bus.pix_y}); end
    checks++; if ({bus.locked, bus.frame_done} !== 2'b00 || bus.frame_sig !== 16'd0) begin failures++; $display("FAIL rmid_state got=%b/%h exp=00/0", {bus.locked, bus.frame_done}, bus.frame_sig); end
    checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL rmid_err got=%0d exp=0", bus.err_count); end
    rst_n = 1'b1;
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL rmid_align got=%b exp=0", bus.locked); end
    clr(); drive_frame(0, -1, VT, BIG);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL rmid_relock got=%b exp=1", bus.locked); end
  endtask
  initial begin
    bus.vga_in = enc(1'b0, 1'b0, 6'd0);
    clr();
    test_reset();
    test_lock();
    test_checker();
    test_short_line();
    test_short_frame();
    test_hsync_stuck();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line.
REQ-002 Parameter H_TOTAL, 800, clocks per line.
REQ-003 Parameter H_START, 144, clocks from hsync assert edge to first active pixel (sync + back porch).
REQ-004 Parameter V_ACTIVE, 480, active lines per frame.
REQ-005 Parameter V_TOTAL, 525, lines per frame.
REQ-006 Parameter V_START, 35, hsync edges from vsync assert edge to first active line.
REQ-007 Parameter SYNC_NEG, 1, 1 = hsync/vsync active-low.
REQ-008 clk  in  1  pixel clock; all logic on rising edge.
REQ-009 rst_n  in  1  reset, synchronous, active-low.
REQ-010 vga_in  in  8  TinyVGA PMOD byte {hsync, B0, G0, R0, vsync, B1, G1, R1}.
REQ-011 pix_valid  out  1  rrggbb/pix_x/pix_y carry an active-area pixel.
REQ-012 rrggbb  out  6  decoded colour {R1,R0,G1,G0,B1,B0}.
REQ-013 pix_x  out  10  active column 0..H_ACTIVE-1.
REQ-014 pix_y  out  10  active row 0..V_ACTIVE-1.
REQ-015 locked  out  1  state == LOCKED.
REQ-016 frame_done  out  1  one-cycle pulse at end of each locked frame.
REQ-017 frame_sig  out  16  signature of last completed locked frame.
REQ-018 err_count  out  8  lock-loss count, saturating at 255.

Function
REQ-019 vga_in SHALL be registered once (stage S1); edge detection compares S1 to its one-cycle-delayed copy; an assert edge is inactive->active per SYNC_NEG.
REQ-020 hcnt (10 bit) SHALL load 0 on the cycle an hsync assert edge is detected in S1, else increment, saturating at 1023.
REQ-021 On each hsync assert edge, hcnt+1 SHALL be compared to H_TOTAL; mismatch is a line error (the first edge after SEARCH exit excluded).
REQ-022 vcnt (10 bit) SHALL load 0 on a vsync assert edge and increment on each hsync assert edge; if both occur in the same cycle vsync wins (vcnt = 0).
REQ-023 Active pixel: hcnt in [H_START, H_START+H_ACTIVE-1] and vcnt in [V_START, V_START+V_ACTIVE-1]; pix_x = hcnt-H_START, pix_y = vcnt-V_START.
REQ-024 Outputs pix_valid, rrggbb, pix_x, pix_y SHALL be registered: a pixel present on vga_in at cycle n appears at cycle n+2.
REQ-025 pix_valid SHALL be 0 unless locked or state is ALIGN; rrggbb SHALL be 0 when pix_valid is 0.
REQ-026 States: SEARCH, ALIGN, LOCKED.
REQ-027 SEARCH -> ALIGN on vsync assert edge.
REQ-028 ALIGN -> LOCKED on the next vsync assert edge if no line error occurred and the hsync edge count since the previous vsync edge equals V_TOTAL; otherwise stay in ALIGN, clear the error record and restart measurement.
REQ-029 LOCKED -> SEARCH on any line error, on hcnt saturating at 1023, or on a vsync edge with line count != V_TOTAL; err_count increments (saturating) on each such transition.
REQ-030 Signature sig (16 bit) SHALL update on every active pixel: sig = {sig[14:0],0} XOR (sig[15] ? 16'h1021 : 0) XOR {10'b0, rrggbb}; sig clears to 0 on every vsync assert edge.
REQ-031 On a vsync assert edge while LOCKED with a valid frame: frame_sig <= sig (including any pixel updated that cycle), frame_done = 1 for exactly one cycle.
REQ-032 No frame_done on the ALIGN->LOCKED transition edge or on a lock-loss edge.

Reset
REQ-033 While rst_n = 0 at a clk edge: state = SEARCH, hcnt = vcnt = 0, sig = 0, frame_sig = 0, err_count = 0, all outputs 0, S1 pipeline cleared to the inactive sync level.
REQ-034 Reset mid-frame SHALL discard the frame; after release the block requires one SEARCH edge and one full ALIGN frame before locked = 1.

Verification
REQ-035 Standard 640x480 source, solid colour 6'b110000, from reset -> locked = 1 at the second vsync edge after the first; every locked frame yields 307200 pix_valid cycles, pix_x 0..639, pix_y 0..479.
REQ-036 Checkerboard source -> frame_sig identical each frame and equal to the model-computed value; frame_done pulses once per 420000 clocks.
REQ-037 One line shortened to 799 clocks while locked -> locked drops at that hsync edge, err_count = 1, relock after 2 further vsync edges.
REQ-038 hsync stuck inactive while locked -> locked drops when hcnt reaches 1023; err_count increments by 1; pix_valid stays 0.
REQ-039 Pixel at hpos 0, vpos 0 driven 6'b000011 -> rrggbb = 6'b000011, pix_x = 0, pix_y = 0, pix_valid = 1, two cycles later.
REQ-040 rst_n pulsed low mid-frame -> all outputs 0 next cycle, err_count = 0, locked = 0 until re-acquisition.
